// File: rtl/ctr_back_sched.sv
// ctr_back_sched: BCH back-end scheduler sequencing KES then Chien per codeword over ping-pong syndrome buffers
module ctr_back_sched #(
  parameter int PARALLELISM     = 3,
  parameter int CNT_BIT_LEN     = 10,
  parameter int KES_CLK_CYCLE   = 20,
  parameter int CHIEN_CLK_CYCLE = 1023
) (
  input  logic clk,
  input  logic in_ctr_Srst_n,
  input  logic in_ctr_en,
  input  logic in_ctr_front_done,
  output logic out_ctr_front_stall,
  output logic out_ctr_wr_sel,
  output logic out_ctr_rd_sel,
  output logic out_ctr_kes_init,
  output logic out_ctr_kes_en,
  output logic out_ctr_kes_done,
  output logic out_ctr_chien_init,
  output logic out_ctr_chien_en,
  output logic out_ctr_done,
  output logic out_ctr_busy,
  output logic out_ctr_ovf
);
  localparam int CHIEN_STEPS = (CHIEN_CLK_CYCLE + PARALLELISM - 1) / PARALLELISM;
  localparam logic [CNT_BIT_LEN-1:0] KES_LAST = CNT_BIT_LEN'(KES_CLK_CYCLE);
  localparam logic [CNT_BIT_LEN-1:0] CHIEN_LAST = CNT_BIT_LEN'(CHIEN_STEPS);
  localparam logic [CNT_BIT_LEN-1:0] CNT_ONE = CNT_BIT_LEN'(1);
  localparam logic [1:0] IDLE = 2'd0, KES = 2'd1, CHIEN = 2'd2;
  logic [1:0] state_q, state_d, pend_q, pend_d;
  logic [CNT_BIT_LEN-1:0] cnt_q, cnt_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, ovf_q, ovf_d;
  logic in_kes, in_chien, kes_last, chien_last, launch, accept;
  always_comb begin
    in_kes = in_ctr_en & (state_q == KES);
    in_chien = in_ctr_en & (state_q == CHIEN);
    kes_last = in_kes & (cnt_q == KES_LAST);
    chien_last = in_chien & (cnt_q == CHIEN_LAST);
    launch = in_ctr_en & ((pend_q != 2'd0) | in_ctr_front_done) & ((state_q == IDLE) | chien_last);
    accept = in_ctr_en & in_ctr_front_done & ((pend_q != 2'd2) | launch);
    pend_d = pend_q + {1'b0, accept} - {1'b0, launch};
    wr_sel_d = wr_sel_q ^ accept;
    rd_sel_d = rd_sel_q ^ launch;
    ovf_d = ovf_q | (in_ctr_en & in_ctr_front_done & !accept);
    state_d = !in_ctr_en ? state_q : launch ? KES : kes_last ? CHIEN : chien_last ? IDLE : state_q;
    cnt_d = !in_ctr_en ? cnt_q
          : (launch | kes_last) ? CNT_ONE
          : chien_last ? '0
          : (state_q != IDLE) ? cnt_q + CNT_ONE : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!in_ctr_Srst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= 2'd0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_ctr_front_stall = pend_q == 2'd2;
  assign out_ctr_wr_sel = wr_sel_q;
  assign out_ctr_rd_sel = rd_sel_q;
  assign out_ctr_kes_init = in_kes & (cnt_q == CNT_ONE);
  assign out_ctr_kes_en = in_kes;
  assign out_ctr_kes_done = kes_last;
  assign out_ctr_chien_init = in_chien & (cnt_q == CNT_ONE);
  assign out_ctr_chien_en = in_chien;
  assign out_ctr_done = chien_last;
  assign out_ctr_busy = state_q != IDLE;
  assign out_ctr_ovf = ovf_q;
endmodule

// File: tb/tb_ctr_back_sched.sv
// tb_ctr_back_sched: scoreboard bench for ctr_back_sched with KES=4, Chien=10/3 -> 4 steps
module tb_ctr_back_sched;
  logic clk = 1'b0;
  logic rst_n, en, fd;
  logic stall, wr_sel, rd_sel, kinit, ken, kdone, cinit, cen, done, busy, ovf;
  logic [10:0] outs;
  int cyc = 0;
  int nvec = 0;
  int nbad = 0;
  int exp_q[$];
  int obs_q[$];
  int e, o, t;
  logic w0;

  ctr_back_sched #(.PARALLELISM(3), .CNT_BIT_LEN(10), .KES_CLK_CYCLE(4), .CHIEN_CLK_CYCLE(10)) dut (
    .clk(clk), .in_ctr_Srst_n(rst_n), .in_ctr_en(en), .in_ctr_front_done(fd),
    .out_ctr_front_stall(stall), .out_ctr_wr_sel(wr_sel), .out_ctr_rd_sel(rd_sel),
    .out_ctr_kes_init(kinit), .out_ctr_kes_en(ken), .out_ctr_kes_done(kdone),
    .out_ctr_chien_init(cinit), .out_ctr_chien_en(cen), .out_ctr_done(done),
    .out_ctr_busy(busy), .out_ctr_ovf(ovf)
  );

  assign outs = {stall, wr_sel, rd_sel, kinit, ken, kdone, cinit, cen, done, busy, ovf};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kinit) obs_q.push_back(cyc * 4);
    if (kdone) obs_q.push_back(cyc * 4 + 1);
    if (cinit) obs_q.push_back(cyc * 4 + 2);
    if (done) obs_q.push_back(cyc * 4 + 3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input int k);
    exp_q.push_back(k * 4);
    exp_q.push_back((k + 3) * 4 + 1);
    exp_q.push_back((k + 4) * 4 + 2);
    exp_q.push_back((k + 7) * 4 + 3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; fd = 1'b0;
    step();
    step();
    nvec++; if (outs !== 11'b0) begin nbad++; $display("FAIL reset_outs got %b want 0", outs); end
    rst_n = 1'b1;
    step();
    nvec++; if (outs !== 11'b0) begin nbad++; $display("FAIL reset_idle got %b want 0", outs); end
    nvec++; if (obs_q.size() != 0) begin nbad++; $display("FAIL reset_events got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_single();
    t = cyc;
    fd = 1'b1;
    word(t + 1);
    step();
    fd = 1'b0;
    nvec++; if ({wr_sel, ken, busy} !== 3'b111) begin nbad++; $display("FAIL single_start got %b want 111", {wr_sel, ken, busy}); end
    repeat (8) step();
    nvec++; if ({busy, rd_sel, wr_sel, stall} !== 4'b0110) begin nbad++; $display("FAIL single_end got %b want 0110", {busy, rd_sel, wr_sel, stall}); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL single_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_back_to_back();
    t = cyc;
    fd = 1'b1; step();
    fd = 1'b0; step();
    fd = 1'b1; step();
    fd = 1'b0;
    word(t + 1);
    word(t + 9);
    repeat (5) step();
    nvec++; if ({done, busy} !== 2'b11) begin nbad++; $display("FAIL b2b_done got %b want 11", {done, busy}); end
    step();
    nvec++; if ({kinit, busy} !== 2'b11) begin nbad++; $display("FAIL b2b_relaunch got %b want 11", {kinit, busy}); end
    repeat (8) step();
    nvec++; if ({busy, stall, rd_sel, wr_sel} !== 4'b0011) begin nbad++; $display("FAIL b2b_end got %b want 0011", {busy, stall, rd_sel, wr_sel}); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL b2b_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_full_ovf();
    w0 = wr_sel;
    t = cyc;
    fd = 1'b1; step();
    fd = 1'b0; step();
    fd = 1'b1; step();
    nvec++; if ({wr_sel, stall} !== {w0, 1'b0}) begin nbad++; $display("FAIL full_one got %b want %b", {wr_sel, stall}, {w0, 1'b0}); end
    step();
    nvec++; if ({wr_sel, stall, ovf} !== {~w0, 2'b10}) begin nbad++; $display("FAIL full_stall got %b want %b", {wr_sel, stall, ovf}, {~w0, 2'b10}); end
    step();
    fd = 1'b0;
    nvec++; if ({wr_sel, stall, ovf} !== {~w0, 2'b11}) begin nbad++; $display("FAIL full_ovf got %b want %b", {wr_sel, stall, ovf}, {~w0, 2'b11}); end
    word(t + 1);
    word(t + 9);
    word(t + 17);
    repeat (3) step();
    nvec++; if (stall !== 1'b1) begin nbad++; $display("FAIL full_stall_hold got %b want 1", stall); end
    step();
    nvec++; if (stall !== 1'b0) begin nbad++; $display("FAIL full_stall_release got %b want 0", stall); end
    repeat (16) step();
    nvec++; if ({busy, stall, ovf} !== 3'b001) begin nbad++; $display("FAIL full_end got %b want 001", {busy, stall, ovf}); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL full_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    t = cyc;
    fd = 1'b1; step();
    fd = 1'b0; step();
    fd = 1'b1; step();
    step();
    fd = 1'b0;
    nvec++; if (stall !== 1'b1) begin nbad++; $display("FAIL simul_full got %b want 1", stall); end
    repeat (4) step();
    nvec++; if (done !== 1'b1) begin nbad++; $display("FAIL simul_done got %b want 1", done); end
    fd = 1'b1; step();
    fd = 1'b0;
    nvec++; if ({kinit, stall, ovf, wr_sel} !== 4'b1100) begin nbad++; $display("FAIL simul_accept got %b want 1100", {kinit, stall, ovf, wr_sel}); end
    word(t + 1);
    word(t + 9);
    word(t + 17);
    word(t + 25);
    repeat (24) step();
    nvec++; if ({busy, stall, ovf} !== 3'b000) begin nbad++; $display("FAIL simul_end got %b want 000", {busy, stall, ovf}); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL simul_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_enable_freeze();
    t = cyc;
    fd = 1'b1; step();
    fd = 1'b0; step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if ({kinit, ken, kdone, cinit, cen, done, busy} !== 7'b0000001) begin nbad++; $display("FAIL freeze_gate%0d got %b want 0000001", i, {kinit, ken, kdone, cinit, cen, done, busy}); end
      step();
    end
    en = 1'b1;
    #1;
    nvec++; if ({ken, kinit, kdone} !== 3'b100) begin nbad++; $display("FAIL freeze_resume got %b want 100", {ken, kinit, kdone}); end
    exp_q.push_back((t + 1) * 4);
    exp_q.push_back((t + 7) * 4 + 1);
    exp_q.push_back((t + 8) * 4 + 2);
    exp_q.push_back((t + 11) * 4 + 3);
    repeat (7) step();
    nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL freeze_end got %b want 0", busy); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL freeze_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  task automatic test_reset_mid();
    t = cyc;
    fd = 1'b1; step();
    fd = 1'b0;
    repeat (5) step();
    nvec++; if ({cen, cinit} !== 2'b10) begin nbad++; $display("FAIL rmid_chien got %b want 10", {cen, cinit}); end
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    nvec++; if (outs !== 11'b0) begin nbad++; $display("FAIL rmid_reset got %b want 0", outs); end
    step();
    nvec++; if (outs !== 11'b0) begin nbad++; $display("FAIL rmid_idle got %b want 0", outs); end
    fd = 1'b1;
    exp_q.push_back((t + 1) * 4);
    exp_q.push_back((t + 4) * 4 + 1);
    exp_q.push_back((t + 5) * 4 + 2);
    word(t + 9);
    step();
    fd = 1'b0;
    nvec++; if (kinit !== 1'b1) begin nbad++; $display("FAIL rmid_restart got %b want 1", kinit); end
    repeat (8) step();
    nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL rmid_end got %b want 0", busy); end
    exp_q.sort(); obs_q.sort();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -4;
      o = obs_q.size() != 0 ? obs_q.pop_front() : -4;
      nvec++; if (o !== e) begin nbad++; $display("FAIL rmid_event got cyc %0d kind %0d want cyc %0d kind %0d", o / 4, o % 4, e / 4, e % 4); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_ovf();
    test_simultaneous();
    test_enable_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
